// File: rtl/riscv_sw_debounce.sv
// riscv_sw_debounce: conditions raw board switches for the IO bridge switch
// register. Each bit passes through a 2-FF synchroniser, then a per-bit
// stability counter that advances on a shared prescaler tick. A bit of `sw`
// only follows its synchronised input after it has differed from `sw` on
// STABLE_TICKS consecutive ticks. A registered pulse and mask flag each update.
module riscv_sw_debounce #(
   parameter int               WIDTH        = 24,
   parameter int               TICK_DIV     = 100000,
   parameter int               STABLE_TICKS = 10,
   parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw,
   output logic             sw_changed,
   output logic [WIDTH-1:0] change_mask,
   output logic             tick
);

   // With TICK_DIV=1 the prescaler never leaves 0; a 1-bit register still exists.
   localparam int PC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CNT_W = $clog2(STABLE_TICKS + 1);

   localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [PC_W-1:0]  pc;
   logic [CNT_W-1:0] cnt      [WIDTH];
   logic [CNT_W-1:0] cnt_next [WIDTH];
   logic [WIDTH-1:0] mature;

   // Two-stage synchroniser; only sync2 is trusted downstream.
   // NOTE: every sequential block uses non-blocking assignments so all
   // registers sample the values from before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= RESET_VAL;
         sync2 <= RESET_VAL;
      end else begin
         sync1 <= sw_raw;
         sync2 <= sync1;
      end
   end

   // Shared prescaler: counts 0..TICK_DIV-1 and wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= '0;
      end else if (tick) begin
         pc <= '0;
      end else begin
         pc <= pc + 1'b1;
      end
   end

   assign tick = (pc == PC_LAST);

   // Per-bit stability decision: clear on equality, advance while different,
   // and mature (flip `sw`) once the count would reach STABLE_TICKS.
   // NOTE: defaults are assigned before the loop so no path leaves a
   // combinational output unassigned, which would infer a latch.
   always_comb begin
      cnt_next = cnt;
      mature   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (sync2[i] == sw[i]) begin
            cnt_next[i] = '0;
         end else if (cnt[i] == CNT_LAST) begin
            cnt_next[i] = '0;
            mature[i]   = tick;
         end else begin
            cnt_next[i] = cnt[i] + 1'b1;
         end
      end
   end

   // Counter array, debounced state and registered change flags.
   // NOTE: the counter array is reset even though it looks like storage,
   // because a partial count surviving reset could later emit a stale update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
         sw          <= RESET_VAL;
         sw_changed  <= 1'b0;
         change_mask <= '0;
      end else begin
         if (tick) begin
            cnt <= cnt_next;
         end
         sw          <= sw ^ mature;
         sw_changed  <= |mature;
         change_mask <= mature;
      end
   end

endmodule

// File: tb/tb_riscv_sw_debounce.sv
// Bench for riscv_sw_debounce. Instance "a" uses TICK_DIV=4, STABLE_TICKS=3,
// RESET_VAL=0; instance "b" uses the boundary set TICK_DIV=1, STABLE_TICKS=1,
// RESET_VAL=all ones. Expected change pulses of instance "a" are queued when a
// raw edge is driven and matched by a monitor when sw_changed fires.
module tb_riscv_sw_debounce;

   localparam int TD = 4;
   localparam int ST = 3;
   localparam int W  = 24;

   typedef struct {
      int           cycle;
      logic [W-1:0] mask;
      logic [W-1:0] swv;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] sw_raw = '0;
   logic [W-1:0] sw;
   logic         sw_changed;
   logic [W-1:0] change_mask;
   logic         tick;

   logic         rst_b = 1'b1;
   logic [W-1:0] sw_raw_b = 24'hFFFFFF;
   logic [W-1:0] sw_b;
   logic         sw_changed_b;
   logic [W-1:0] change_mask_b;
   logic         tick_b;

   int   checks = 0;
   int   errors = 0;
   int   cyc;
   exp_t exp_q[$];
   exp_t mon_e;

   riscv_sw_debounce #(.WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST), .RESET_VAL(24'h000000)) u_dut_a (
      .clk(clk), .rst(rst), .sw_raw(sw_raw), .sw(sw),
      .sw_changed(sw_changed), .change_mask(change_mask), .tick(tick)
   );

   riscv_sw_debounce #(.WIDTH(W), .TICK_DIV(1), .STABLE_TICKS(1), .RESET_VAL(24'hFFFFFF)) u_dut_b (
      .clk(clk), .rst(rst_b), .sw_raw(sw_raw_b), .sw(sw_b),
      .sw_changed(sw_changed_b), .change_mask(change_mask_b), .tick(tick_b)
   );

   always #5 clk = ~clk;

   // Cycle index since reset release: cycle 0 is the period before the first edge.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // Monitor: every pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (sw_changed) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse: cycle=%0d mask=%h sw=%h, required no pulse", cyc, change_mask, sw);
            end else begin
               mon_e = exp_q.pop_front();
               if (cyc !== mon_e.cycle || change_mask !== mon_e.mask || sw !== mon_e.swv) begin
                  errors++;
                  $display("FAIL pulse: cycle=%0d mask=%h sw=%h, required cycle=%0d mask=%h sw=%h",
                           cyc, change_mask, sw, mon_e.cycle, mon_e.mask, mon_e.swv);
               end
            end
         end else begin
            checks++;
            if (change_mask !== '0) begin
               errors++;
               $display("FAIL idle_mask: mask=%h with sw_changed=0, required 0", change_mask);
            end
         end
      end
   end

   // Expected pulse cycle for a raw change driven during cycle c.
   task automatic push_exp(input int c, input logic [W-1:0] mask, input logic [W-1:0] v);
      exp_t e;
      int   t;
      t = c + 2;
      while (t % TD != TD - 1) t++;
      e.cycle = t + (ST - 1) * TD + 1;
      e.mask  = mask;
      e.swv   = v;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d pulses outstanding after %0d cycles, required 0", exp_q.size(), budget);
         exp_q.delete();
      end
   endtask

   task automatic apply_reset;
      @(negedge clk);
      sw_raw = '0;
      rst    = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic align1;
      @(negedge clk);
      while (cyc % TD != 1) @(negedge clk);
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (sw !== 24'h000000 || sw_changed !== 1'b0 || change_mask !== '0 || tick !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: sw=%h chg=%b mask=%h tick=%b, required 000000 0 000000 0",
                  sw, sw_changed, change_mask, tick);
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_idle;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         checks++;
         if (tick !== ((k % TD) == TD - 1) || sw !== '0 || sw_changed !== 1'b0) begin
            errors++;
            $display("FAIL idle_tick: cycle %0d tick=%b sw=%h chg=%b, required tick=%b sw=000000 chg=0",
                     k, tick, sw, sw_changed, ((k % TD) == TD - 1));
         end
      end
   endtask

   task automatic test_clean_edge;
      @(negedge clk);
      sw_raw[0] = 1'b1;
      push_exp(cyc, 24'h000001, 24'h000001);
      wait_drain(40);
   endtask

   task automatic test_glitch;
      int c;
      apply_reset();
      align1();
      sw_raw[5] = 1'b1;
      repeat (7) @(negedge clk);
      sw_raw[5] = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (sw !== '0) begin
         errors++;
         $display("FAIL glitch_reject: sw=%h, required 000000", sw);
      end
      c = cyc;
      sw_raw[5] = 1'b1;
      push_exp(c, 24'h000020, 24'h000020);
      wait_drain(40);
   endtask

   task automatic test_simultaneous;
      apply_reset();
      align1();
      sw_raw = 24'hA50003;
      push_exp(cyc, 24'hA50003, 24'hA50003);
      wait_drain(40);
   endtask

   task automatic test_reset_mid;
      align1();
      sw_raw = 24'hA50007;
      repeat (6) @(negedge clk);
      checks++;
      if (sw !== 24'hA50003) begin
         errors++;
         $display("FAIL mid_hold: sw=%h, required a50003", sw);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (sw !== '0 || sw_changed !== 1'b0 || change_mask !== '0) begin
         errors++;
         $display("FAIL async_reset: sw=%h chg=%b mask=%h, required 000000 0 000000",
                  sw, sw_changed, change_mask);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      push_exp(0, 24'hA50007, 24'hA50007);
      wait_drain(40);
   endtask

   task automatic test_boundary;
      logic [W-1:0] e_sw;
      logic [W-1:0] e_mask;
      logic         e_chg;
      @(posedge clk);
      #1 rst_b = 1'b0;
      @(negedge clk);
      checks++;
      if (sw_b !== 24'hFFFFFF || tick_b !== 1'b1 || sw_changed_b !== 1'b0) begin
         errors++;
         $display("FAIL b_reset: sw=%h tick=%b chg=%b, required ffffff 1 0", sw_b, tick_b, sw_changed_b);
      end
      sw_raw_b[23] = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         e_chg  = (k == 3);
         e_sw   = (k >= 3) ? 24'h7FFFFF : 24'hFFFFFF;
         e_mask = (k == 3) ? 24'h800000 : 24'h000000;
         checks++;
         if (sw_b !== e_sw || sw_changed_b !== e_chg || change_mask_b !== e_mask) begin
            errors++;
            $display("FAIL b_drop: cycle +%0d sw=%h chg=%b mask=%h, required %h %b %h",
                     k, sw_b, sw_changed_b, change_mask_b, e_sw, e_chg, e_mask);
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_clean_edge();
      test_glitch();
      test_simultaneous();
      test_reset_mid();
      test_boundary();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
